// File: rtl/traffic_pkg.sv
// Shared phase encoding, lamp codes and lamp decode for the intersection controller.
package traffic_pkg;

    typedef enum logic [2:0] {
        MG  = 3'd0,
        MY  = 3'd1,
        AR1 = 3'd2,
        SG  = 3'd3,
        SY  = 3'd4,
        AR2 = 3'd5
    } phase_e;

    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;

    typedef struct packed {
        logic [2:0] main_l;
        logic [2:0] side_l;
        logic       walk;
    } lamp_t;

    // Unknown codes decode to all-red so no state can show two non-red roads.
    function automatic lamp_t decode_lamps(input phase_e p);
        lamp_t l;
        l = '{main_l: RED, side_l: RED, walk: 1'b0};
        case (p)
            MG:      l.main_l = GREEN;
            MY:      l.main_l = YELLOW;
            SG:      begin l.side_l = GREEN; l.walk = 1'b1; end
            SY:      l.side_l = YELLOW;
            default: ;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Per-phase cycle counter: clears on state change, optionally holds at its terminal value.
module phase_timer #(
    parameter int unsigned TW = 8
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          clear,
    input  logic          sat,
    input  logic [TW-1:0] last,
    output logic          done_c
);

    logic [TW-1:0] count;

    assign done_c = (count == last);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (!(sat && done_c)) begin
            count <= count + TW'(1);
        end
    end

endmodule

// File: rtl/intersection_controller.sv
// Demand-driven two-road phase controller: main rests on green until side or pedestrian demand.
module intersection_controller
    import traffic_pkg::*;
#(
    parameter int unsigned GREEN_MIN  = 8,
    parameter int unsigned SIDE_GREEN = 6,
    parameter int unsigned YELLOW_T   = 3,
    parameter int unsigned ALLRED_T   = 2,
    parameter int unsigned TW         = 8
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       side_sensor,
    input  logic       ped_req,
    output logic [2:0] main_lights,
    output logic [2:0] side_lights,
    output logic       walk,
    output logic [2:0] phase
);

    phase_e        state;
    phase_e        next_state;
    logic          ped_pending;
    logic [TW-1:0] last;
    logic          t_done;
    logic          t_clear;
    logic          t_sat;
    logic          demand;
    lamp_t         lamps_nxt;

    // Terminal timer value for the phase currently held.
    always_comb begin
        last = '0;
        case (state)
            MG:      last = TW'(GREEN_MIN - 1);
            MY, SY:  last = TW'(YELLOW_T - 1);
            AR1, AR2: last = TW'(ALLRED_T - 1);
            SG:      last = TW'(SIDE_GREEN - 1);
            default: last = '0;
        endcase
    end

    assign demand = side_sensor | ped_pending | ped_req;

    always_comb begin
        next_state = state;
        case (state)
            MG:      if (t_done && demand) next_state = MY;
            MY:      if (t_done) next_state = AR1;
            AR1:     if (t_done) next_state = SG;
            SG:      if (t_done) next_state = SY;
            SY:      if (t_done) next_state = AR2;
            AR2:     if (t_done) next_state = MG;
            default: next_state = AR2;
        endcase
    end

    assign t_clear   = (next_state != state);
    assign t_sat     = (state == MG);
    assign lamps_nxt = decode_lamps(next_state);

    phase_timer #(.TW(TW)) u_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (t_clear),
        .sat     (t_sat),
        .last    (last),
        .done_c  (t_done)
    );

    // Lamps are registered from the next-state decode so they track the state register exactly.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= AR2;
            ped_pending <= 1'b0;
            main_lights <= RED;
            side_lights <= RED;
            walk        <= 1'b0;
        end else begin
            state       <= next_state;
            main_lights <= lamps_nxt.main_l;
            side_lights <= lamps_nxt.side_l;
            walk        <= lamps_nxt.walk;
            if (next_state == SG && state != SG) begin
                ped_pending <= 1'b0;
            end else if (ped_req) begin
                ped_pending <= 1'b1;
            end
        end
    end

    assign phase = state;

endmodule

// File: tb/tb_intersection_controller.sv
// Directed bench for intersection_controller with short phase durations.
module tb_intersection_controller;
    import traffic_pkg::*;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       side_sensor;
    logic       ped_req;
    logic [2:0] main_lights;
    logic [2:0] side_lights;
    logic       walk;
    logic [2:0] phase;

    int vectors    = 0;
    int miscompares = 0;
    int exp_q[$];

    intersection_controller #(
        .GREEN_MIN  (4),
        .SIDE_GREEN (3),
        .YELLOW_T   (2),
        .ALLRED_T   (1),
        .TW         (8)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .side_sensor (side_sensor),
        .ped_req     (ped_req),
        .main_lights (main_lights),
        .side_lights (side_lights),
        .walk        (walk),
        .phase       (phase)
    );

    always #5 clock = ~clock;

    // Expected {phase, main, side, walk} for each legal phase code.
    function automatic logic [9:0] model(input int p);
        case (p)
            0:       return {3'd0, 3'b001, 3'b100, 1'b0};
            1:       return {3'd1, 3'b010, 3'b100, 1'b0};
            2:       return {3'd2, 3'b100, 3'b100, 1'b0};
            3:       return {3'd3, 3'b100, 3'b001, 1'b1};
            4:       return {3'd4, 3'b100, 3'b010, 1'b0};
            default: return {3'd5, 3'b100, 3'b100, 1'b0};
        endcase
    endfunction

    function automatic logic [9:0] obs_vec();
        return {phase, main_lights, side_lights, walk};
    endfunction

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Both roads may never be non-red at once.
    always @(negedge clock) begin
        vectors++;
        assert (!(main_lights != 3'b100 && side_lights != 3'b100)) else begin
            miscompares++;
            $error("FAIL safety: observed main %b side %b expected one red", main_lights, side_lights);
        end
    end

    task automatic push(input int p, input int n);
        repeat (n) exp_q.push_back(p);
    endtask

    task automatic push_cycle();
        push(0, 4); push(1, 2); push(2, 1); push(3, 3); push(4, 2); push(5, 1);
    endtask

    task automatic do_reset(input logic sensor);
        @(negedge clock);
        reset_n     = 1'b0;
        ped_req     = 1'b0;
        side_sensor = sensor;
        #1 chk("reset", obs_vec(), model(5));
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    // Walk the expected phase queue one edge at a time; ped_req is high only before edges pa/pb.
    task automatic run_seq(input string tag, input int pa, input int pb);
        for (int k = 1; k <= exp_q.size(); k++) begin
            ped_req = (k == pa || k == pb);
            @(posedge clock);
            #1 chk($sformatf("%s[%0d]", tag, k), obs_vec(), model(exp_q[k-1]));
        end
        ped_req = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        reset_n     = 1'b0;
        side_sensor = 1'b0;
        ped_req     = 1'b0;

        do_reset(1'b0);
        push(0, 50);
        run_seq("idle", 0, 0);

        do_reset(1'b1);
        push_cycle(); push_cycle(); push(0, 4);
        run_seq("sensor", 0, 0);

        do_reset(1'b0);
        push_cycle(); push(0, 12);
        run_seq("ped", 3, 0);

        do_reset(1'b0);
        push_cycle(); push_cycle(); push(0, 6);
        run_seq("ped_sg", 3, 9);

        do_reset(1'b0);
        push_cycle(); push(0, 8);
        run_seq("ped_entry", 3, 8);

        do_reset(1'b1);
        push(0, 4); push(1, 2); push(2, 1); push(3, 2);
        run_seq("pre_rst", 9, 0);
        #3 reset_n = 1'b0;
        #1 chk("mid_rst", obs_vec(), model(5));
        side_sensor = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        push(0, 10);
        run_seq("post_rst", 0, 0);

        force dut.state = phase_e'(3'd7);
        #1 release dut.state;
        #1 chk("illegal", obs_vec(), {3'd7, 3'b001, 3'b100, 1'b0});
        @(posedge clock);
        #1 chk("recover", obs_vec(), model(5));
        @(posedge clock);
        #1 chk("recover_mg", obs_vec(), model(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/intersection_controller.md
# intersection_controller

Sequences a two-road intersection: drives one-hot light codes for the main road and side road, and a pedestrian walk signal for crossing the main road. It replaces the free-running three-state light cycler with a demand-driven phase controller: main road rests on green until a side-road vehicle or pedestrian request arrives, then steps through timed yellow, all-red and side-green phases. It sits directly above the lamp drivers and is the only writer of their codes.

## Interface
- `GREEN_MIN`, default 8: minimum main-green cycles before a demand is served (≥1).
- `SIDE_GREEN`, default 6: side-green duration in cycles (≥1).
- `YELLOW_T`, default 3: yellow duration in cycles, both roads (≥1).
- `ALLRED_T`, default 2: all-red clearance duration in cycles (≥1).
- `TW`, default 8: timer width; every duration must be ≤ 2^TW.
- `clock` in 1: sole clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `side_sensor` in 1: level; vehicle waiting on side road.
- `ped_req` in 1: pedestrian button; any width pulse, sampled each edge.
- `main_lights` out 3: one-hot, red=100, yellow=010, green=001.
- `side_lights` out 3: same encoding.
- `walk` out 1: pedestrians may cross main road.
- `phase` out 3: current state encoding, for debug/observation.

## Operation
- States (encoding): MG=0 main green, MY=1 main yellow, AR1=2 all-red before side, SG=3 side green, SY=4 side yellow, AR2=5 all-red before main. Codes 6–7 illegal → next edge goes to AR2 with timer 0.
- Lights decode: MG main=001 side=100; MY main=010 side=100; AR1/AR2 both 100; SG main=100 side=001; SY main=100 side=010. `walk`=1 only in SG.
- Phase timer: cleared to 0 on every state entry, increments each cycle in state. Timed state exits when timer == DUR−1, so each lasts exactly DUR cycles: MY, SY → YELLOW_T; AR1, AR2 → ALLRED_T; SG → SIDE_GREEN.
- MG: timer saturates at GREEN_MIN−1. Exit to MY at an edge where timer == GREEN_MIN−1 and (side_sensor | ped_pending | ped_req). No demand → stays MG indefinitely.
- ped_pending: set at any edge with ped_req=1; cleared at edge entering SG (entry clear dominates a ped_req on that same edge). ped_req during SG/SY/AR2 re-arms it for the next cycle.
- Transitions: MG→MY→AR1→SG→SY→AR2→MG.
- Never are both roads non-red simultaneously, in any state including illegal-code recovery.

## Timing
- Reset (reset_n=0, asynchronous): state=AR2, timer=0, ped_pending=0 → main_lights=100, side_lights=100, walk=0, phase=5. After release, ALLRED_T cycles in AR2, then MG.
- Outputs are combinational decode of the state register only (Moore); they change in the cycle after the transition edge, no input-to-output path.
- Demand latency: demand present at an edge where MG timer is saturated → MY visible after that same edge.
- Demand arriving mid-MG: served at the edge where timer reaches GREEN_MIN−1.
- side_sensor dropping during MY or later: no abort; sequence completes.
- Reset asserted mid-phase: immediate return to reset values; pending request discarded.
- Full cycle length from leaving MG to re-entering MG: 2·YELLOW_T + 2·ALLRED_T + SIDE_GREEN cycles.

## Structure
- Package `traffic_pkg`: state enum (6 codes), light constants RED/YELLOW/GREEN, light-pair decode function.
- One sub-module natural: `phase_timer` (TW-bit counter with sync clear on state change, saturate option, `done` compare against a duration input).
- Top holds state register, ped_pending flop, next-state logic, output decode.

## Test plan
Parameters: GREEN_MIN=4, SIDE_GREEN=3, YELLOW_T=2, ALLRED_T=1.
- Reset, no demand for 50 cycles → 1 cycle AR2 (both 100) then MG held: main=001, side=100, walk=0 throughout.
- side_sensor=1 held from reset release → MG exactly 4 cycles, MY 2, AR1 1, SG 3 (side=001, walk=1), SY 2, AR2 1, back to MG; sensor still high → repeats.
- 1-cycle ped_req at MG timer=1, sensor=0 → MY entered after MG's 4th cycle; walk=1 for exactly 3 cycles; pending clear afterwards, MG then rests.
- ped_req pulse during SG → after return to MG, next MY after exactly 4 MG cycles.
- reset_n pulsed low mid-SG → outputs immediately 100/100, walk=0, phase=5; pending request lost.
- Force state code 7 via bench → next edge phase=5, both red; assertion every cycle that main and side are never both non-red.
